// File: rtl/fwrisc_dbg_pkg.sv
// Shared types for the fwrisc debug register-file port.
// Holds the controller state enum, address width and address helper.
package fwrisc_dbg_pkg;

    localparam int REG_AW = 6;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_WRITE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } dbg_state_t;

    // Register index step; wraps 63 -> 0.
    function automatic reg_addr_t addr_next(reg_addr_t a);
        return a + reg_addr_t'(1);
    endfunction

endpackage

// File: rtl/fwrisc_regfile_dbg_if.sv
// Debug request/response bus for the fwrisc register-file debug port.
// master = debugger side, slave = fwrisc_regfile_dbg.
interface fwrisc_regfile_dbg_if;
    import fwrisc_dbg_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    reg_addr_t   req_addr;
    logic [5:0]  req_len;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err, rsp_last
    );

endinterface

// File: rtl/fwrisc_regfile_dbg.sv
// Debug access to the fwrisc register file: halts the core, then does a
// single write or a burst read (addresses wrap mod 64), one beat per resp.
// Ports: clock, reset (async, active-high); dbg = request/response bus;
// halt_req/halted = core stall handshake; dbg_raddr/dbg_rdata (one-cycle
// read latency), dbg_waddr/dbg_wdata/dbg_wen = regfile access.
module fwrisc_regfile_dbg
    import fwrisc_dbg_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    fwrisc_regfile_dbg_if.slave  dbg,
    output logic                 halt_req,
    input  logic                 halted,
    output reg_addr_t            dbg_raddr,
    input  logic [31:0]          dbg_rdata,
    output reg_addr_t            dbg_waddr,
    output logic [31:0]          dbg_wdata,
    output logic                 dbg_wen
);

    localparam int CW = (HALT_TIMEOUT > 255) ? $clog2(HALT_TIMEOUT + 1) : 8;
    // Last count value before the wait is declared failed.
    localparam logic [CW-1:0] TLIM = CW'(HALT_TIMEOUT - 1);

    dbg_state_t  state;
    logic        write_q;
    reg_addr_t   addr_q;
    logic [5:0]  rem_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] cnt_q;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        rsp_last_q;

    assign dbg.req_ready = req_ready_q;
    assign dbg.rsp_valid = rsp_valid_q;
    assign dbg.rsp_data  = rsp_data_q;
    assign dbg.rsp_err   = rsp_err_q;
    assign dbg.rsp_last  = rsp_last_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            halt_req    <= 1'b0;
            dbg_raddr   <= '0;
            dbg_waddr   <= '0;
            dbg_wdata   <= '0;
            dbg_wen     <= 1'b0;
        end else begin
            dbg_wen <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (dbg.req_valid) begin
                        write_q     <= dbg.req_write;
                        addr_q      <= dbg.req_addr;
                        rem_q       <= dbg.req_write ? 6'd0 : dbg.req_len;
                        wdata_q     <= dbg.req_wdata;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        halt_req    <= 1'b1;
                        state       <= ST_HALT_WAIT;
                    end
                end
                ST_HALT_WAIT: begin
                    if (halted) begin
                        if (write_q) begin
                            // r0 is hardwired; ack without touching it.
                            dbg_wen   <= (addr_q != '0);
                            dbg_waddr <= addr_q;
                            dbg_wdata <= wdata_q;
                            state     <= ST_WRITE;
                        end else begin
                            dbg_raddr <= addr_q;
                            state     <= ST_ISSUE;
                        end
                    end else if (cnt_q == TLIM) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_last_q  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_last_q  <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= dbg_rdata;
                    rsp_err_q   <= 1'b0;
                    rsp_last_q  <= (rem_q == 6'd0);
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (dbg.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        // An error response always ends the transaction.
                        if (!rsp_err_q && rem_q != 6'd0) begin
                            addr_q    <= addr_next(addr_q);
                            dbg_raddr <= addr_next(addr_q);
                            rem_q     <= rem_q - 6'd1;
                            state     <= ST_ISSUE;
                        end else begin
                            req_ready_q <= 1'b1;
                            halt_req    <= 1'b0;
                            dbg_raddr   <= '0;
                            cnt_q       <= '0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_dbg.sv
// Bench for fwrisc_regfile_dbg: directed cases plus random transactions
// checked against a transaction-level model of registers and responses.
module tb_fwrisc_regfile_dbg;
    import fwrisc_dbg_pkg::*;

    localparam int HT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fwrisc_regfile_dbg_if dbg_bus ();

    logic        halt_req;
    logic        halted = 1'b0;
    reg_addr_t   dbg_raddr;
    logic [31:0] dbg_rdata;
    reg_addr_t   dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        dbg_wen;

    fwrisc_regfile_dbg #(.HALT_TIMEOUT(HT)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .dbg       (dbg_bus),
        .halt_req  (halt_req),
        .halted    (halted),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .dbg_wen   (dbg_wen)
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_val(int i);
        if (i == 0) return 32'h0;
        return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    // Core: raises halted h_delay cycles after halt_req, or never.
    int h_delay = 0;
    bit h_never = 1'b0;
    int h_cnt = 0;
    always @(posedge clock) begin
        if (!halt_req) begin
            h_cnt  <= 0;
            halted <= 1'b0;
        end else begin
            h_cnt  <= h_cnt + 1;
            halted <= !h_never && (h_cnt >= h_delay);
        end
    end

    // Register file seen by the DUT, one-cycle read latency.
    logic [31:0] rf [64];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) rf[i] <= init_val(i);
        end else if (dbg_wen && dbg_waddr != 6'd0) begin
            rf[dbg_waddr] <= dbg_wdata;
        end
        dbg_rdata <= rf[dbg_raddr];
    end

    // Reference model state.
    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        l;
    } beat_t;
    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] ref_regs [64];
    beat_t       exp_q [$];
    wr_t         wr_q [$];
    logic [31:0] got_q [$];
    int          last_cnt = 0;
    int          wen_cnt = 0;
    bit          raddr_seen = 1'b0;

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_regs[i] = init_val(i);
    endtask

    // Per-cycle compare against the model.
    initial begin
        bit          hold_v = 1'b0;
        logic [31:0] hold_d = '0;
        logic        hold_e = 1'b0;
        logic        hold_l = 1'b0;
        logic [5:0]  hold_ra = '0;
        int          cyc = 0;
        int          last_hs = -100;
        beat_t       b;
        wr_t         w;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                check("ready_vs_halt", 32'(dbg_bus.req_ready), 32'(!halt_req));
                if (dbg_bus.req_ready) check("idle_raddr", 32'(dbg_raddr), 0);
                if (dbg_raddr != 6'd0) raddr_seen = 1'b1;
                if (hold_v) begin
                    check("hold_valid", 32'(dbg_bus.rsp_valid), 1);
                    check("hold_data", dbg_bus.rsp_data, hold_d);
                    check("hold_err", 32'(dbg_bus.rsp_err), 32'(hold_e));
                    check("hold_last", 32'(dbg_bus.rsp_last), 32'(hold_l));
                    check("hold_raddr", 32'(dbg_raddr), 32'(hold_ra));
                end
                if (dbg_wen) begin
                    wen_cnt++;
                    if (wr_q.size() == 0) begin
                        check("wen_unexpected", 32'(dbg_waddr), 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        check("wen_addr", 32'(dbg_waddr), 32'(w.a));
                        check("wen_data", dbg_wdata, w.d);
                    end
                end
                if (dbg_bus.rsp_valid && dbg_bus.rsp_ready) begin
                    check("beat_spacing", 32'(cyc - last_hs >= 3), 1);
                    last_hs = cyc;
                    got_q.push_back(dbg_bus.rsp_data);
                    if (dbg_bus.rsp_last) last_cnt++;
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", dbg_bus.rsp_data, 32'hFFFF_FFFF);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", dbg_bus.rsp_data, b.d);
                        check("beat_err", 32'(dbg_bus.rsp_err), 32'(b.e));
                        check("beat_last", 32'(dbg_bus.rsp_last), 32'(b.l));
                    end
                    hold_v = 1'b0;
                end else if (dbg_bus.rsp_valid) begin
                    hold_v  = 1'b1;
                    hold_d  = dbg_bus.rsp_data;
                    hold_e  = dbg_bus.rsp_err;
                    hold_l  = dbg_bus.rsp_last;
                    hold_ra = dbg_raddr;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_txn(bit wr, logic [5:0] a, logic [5:0] l,
                             logic [31:0] wd, int hd, bit never);
        beat_t b;
        wr_t   w;
        h_delay = hd;
        h_never = never;
        if (never) begin
            b.d = 32'h0; b.e = 1'b1; b.l = 1'b1;
            exp_q.push_back(b);
        end else if (wr) begin
            b.d = 32'h0; b.e = 1'b0; b.l = 1'b1;
            exp_q.push_back(b);
            if (a != 6'd0) begin
                w.a = a; w.d = wd;
                wr_q.push_back(w);
                ref_regs[a] = wd;
            end
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                logic [5:0] ai;
                ai = a + 6'(i);
                b.d = (ai == 6'd0) ? 32'h0 : ref_regs[ai];
                b.e = 1'b0;
                b.l = (i == int'(l));
                exp_q.push_back(b);
            end
        end
        dbg_bus.req_valid = 1'b1;
        dbg_bus.req_write = wr;
        dbg_bus.req_addr  = a;
        dbg_bus.req_len   = l;
        dbg_bus.req_wdata = wd;
        tick();
        dbg_bus.req_valid = 1'b0;
        check("accepted", 32'(dbg_bus.req_ready), 0);
    endtask

    // mode 0: random ready, 1: always ready, 2: stall 10 cycles on beat 0
    task automatic finish_txn(int mode);
        int n = 0;
        int stall = 0;
        while (!dbg_bus.req_ready && n < 300) begin
            unique case (mode)
                0: dbg_bus.rsp_ready = ($urandom_range(0, 2) != 0);
                1: dbg_bus.rsp_ready = 1'b1;
                default: begin
                    if (dbg_bus.rsp_valid) stall++;
                    dbg_bus.rsp_ready = (stall > 10);
                end
            endcase
            tick();
            n++;
        end
        check("txn_done", 32'(n < 300), 1);
        check("exp_drained", 32'(exp_q.size()), 0);
        check("wr_drained", 32'(wr_q.size()), 0);
    endtask

    task automatic run_txn(bit wr, logic [5:0] a, logic [5:0] l,
                           logic [31:0] wd, int hd, bit never, int mode);
        got_q.delete();
        last_cnt = 0;
        wen_cnt = 0;
        raddr_seen = 1'b0;
        start_txn(wr, a, l, wd, hd, never);
        finish_txn(mode);
    endtask

    initial begin
        int n;
        dbg_bus.req_valid = 1'b0;
        dbg_bus.req_write = 1'b0;
        dbg_bus.req_addr  = '0;
        dbg_bus.req_len   = '0;
        dbg_bus.req_wdata = '0;
        dbg_bus.rsp_ready = 1'b0;
        init_ref();

        #22;
        check("rst_req_ready", 32'(dbg_bus.req_ready), 1);
        check("rst_rsp_valid", 32'(dbg_bus.rsp_valid), 0);
        check("rst_rsp_data", dbg_bus.rsp_data, 0);
        check("rst_rsp_err", 32'(dbg_bus.rsp_err), 0);
        check("rst_rsp_last", 32'(dbg_bus.rsp_last), 0);
        check("rst_halt_req", 32'(halt_req), 0);
        check("rst_wen", 32'(dbg_wen), 0);
        check("rst_raddr", 32'(dbg_raddr), 0);
        check("rst_waddr", 32'(dbg_waddr), 0);
        check("rst_wdata", dbg_wdata, 0);
        tick();
        reset = 1'b0;
        tick();

        run_txn(1'b1, 6'd5, 6'd0, 32'hDEAD_BEEF, 1, 1'b0, 1);
        check("w5_wen_cnt", 32'(wen_cnt), 1);
        check("w5_beats", 32'(got_q.size()), 1);
        check("w5_ack_data", got_q[0], 32'h0);
        check("w5_halt_low", 32'(halt_req), 0);

        run_txn(1'b1, 6'd0, 6'd0, 32'h1234_5678, 0, 1'b0, 1);
        check("w0_wen_cnt", 32'(wen_cnt), 0);
        check("w0_beats", 32'(got_q.size()), 1);

        run_txn(1'b0, 6'd62, 6'd3, 32'h0, 2, 1'b0, 1);
        check("r62_beats", 32'(got_q.size()), 4);
        if (got_q.size() == 4) begin
            check("r62_b0", got_q[0], 32'hA500_3E3E);
            check("r62_b1", got_q[1], 32'hA500_3F3F);
            check("r62_b2", got_q[2], 32'h0);
            check("r62_b3", got_q[3], 32'hA500_0101);
        end
        check("r62_lasts", 32'(last_cnt), 1);

        run_txn(1'b0, 6'd7, 6'd1, 32'h0, 0, 1'b0, 2);
        check("stall_beats", 32'(got_q.size()), 2);
        check("stall_lasts", 32'(last_cnt), 1);

        run_txn(1'b0, 6'd3, 6'd2, 32'h0, 0, 1'b1, 1);
        check("to_beats", 32'(got_q.size()), 1);
        check("to_wen_cnt", 32'(wen_cnt), 0);
        check("to_no_issue", 32'(raddr_seen), 0);

        got_q.delete();
        start_txn(1'b0, 6'd10, 6'd3, 32'h0, 0, 1'b0);
        dbg_bus.rsp_ready = 1'b1;
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("rst_mid_reach", 32'(n < 100), 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(dbg_bus.req_ready), 1);
        check("mid_rst_valid", 32'(dbg_bus.rsp_valid), 0);
        check("mid_rst_data", dbg_bus.rsp_data, 0);
        check("mid_rst_halt", 32'(halt_req), 0);
        check("mid_rst_raddr", 32'(dbg_raddr), 0);
        check("mid_rst_wen", 32'(dbg_wen), 0);
        exp_q.delete();
        wr_q.delete();
        init_ref();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_valid", 32'(dbg_bus.rsp_valid), 0);
            check("post_rst_ready", 32'(dbg_bus.req_ready), 1);
        end

        for (int t = 0; t < 60; t++) begin
            bit         wr;
            bit         nv;
            logic [5:0] a;
            logic [5:0] l;
            wr = 1'($urandom_range(0, 1));
            nv = ($urandom_range(0, 7) == 0);
            a  = 6'($urandom_range(0, 63));
            l  = 6'($urandom_range(0, 4));
            run_txn(wr, a, l, $urandom, $urandom_range(0, 2), nv, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
